// File: rtl/tof_i2c_txn_sequencer_if.sv
// Command, write-stream, read-stream, status and I2C-engine signals of the
// ToF register-transaction sequencer, bundled for a single port connection.
interface tof_i2c_txn_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_read;
  logic [6:0]  cmd_slave_addr;
  logic [15:0] cmd_reg_addr;
  logic [16:0] cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        i2c_start;
  logic [6:0]  i2c_slave_addr;
  logic [15:0] i2c_reg_addr;
  logic        i2c_is_read;
  logic [16:0] i2c_nb_bytes;
  logic [7:0]  i2c_data_wr;
  logic [7:0]  i2c_data_rd;
  logic        i2c_ready;
  logic        i2c_reset;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_is_read, cmd_slave_addr, cmd_reg_addr, cmd_len,
    input  wr_data, wr_valid, i2c_data_rd, i2c_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, error, err_code,
    output i2c_start, i2c_slave_addr, i2c_reg_addr, i2c_is_read, i2c_nb_bytes,
    output i2c_data_wr, i2c_reset
  );

  // Controller plus engine side, driving the sequencer.
  modport master (
    output cmd_valid, cmd_is_read, cmd_slave_addr, cmd_reg_addr, cmd_len,
    output wr_data, wr_valid, i2c_data_rd, i2c_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, error, err_code,
    input  i2c_start, i2c_slave_addr, i2c_reg_addr, i2c_is_read, i2c_nb_bytes,
    input  i2c_data_wr, i2c_reset
  );
endinterface

// File: rtl/tof_i2c_txn_sequencer.sv
// Command-level front end for the byte-level I2C master engine (ToF path).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// CHECK    | validate length, load engine address/count fields
// PREFETCH | write only: wait for the first write byte
// START    | one-cycle start pulse to the engine, arm timeout
// XFER     | per engine byte pulse: count down, stream data
// GUARD    | let the engine reach STOP/IDLE, engine pulses ignored
// FINISH   | command completed, done pulse follows
// ABORT    | engine reset pulse, error pulse follows
module tof_i2c_txn_sequencer #(
  parameter int unsigned MAX_LEN     = 512,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned GUARD_CYC   = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  tof_i2c_txn_sequencer_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GRD_W = $clog2(GUARD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PREFETCH, S_START, S_XFER, S_GUARD, S_FINISH, S_ABORT
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  slave_q, slave_d;
  logic [15:0] reg_q, reg_d;
  logic        is_read_q, is_read_d;
  logic [16:0] len_q, len_d;
  logic [16:0] remaining_q, remaining_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GRD_W-1:0] grd_q, grd_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [6:0]  i2c_slave_q, i2c_slave_d;
  logic [15:0] i2c_reg_q, i2c_reg_d;
  logic        i2c_is_read_q, i2c_is_read_d;
  logic [16:0] i2c_nb_q, i2c_nb_d;
  logic [7:0]  i2c_wr_q, i2c_wr_d;

  logic bad_len, byte_evt, need_next, tmo_hit;
  logic cmd_ready_c, wr_ready_c, i2c_start_c, i2c_reset_c;

  // Shared decode of the current cycle's events.
  always_comb begin
    bad_len   = (len_q == 17'd0) || (len_q > 17'(MAX_LEN));
    byte_evt  = (state_q == S_XFER) && bus.i2c_ready;
    need_next = byte_evt && !is_read_q && (remaining_q > 17'd1);
    tmo_hit   = (state_q == S_XFER) && !bus.i2c_ready && (tmo_q == TMO_W'(1));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      slave_q       <= '0;
      reg_q         <= '0;
      is_read_q     <= 1'b0;
      len_q         <= '0;
      remaining_q   <= '0;
      tmo_q         <= '0;
      grd_q         <= '0;
      err_code_q    <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      i2c_slave_q   <= '0;
      i2c_reg_q     <= '0;
      i2c_is_read_q <= 1'b0;
      i2c_nb_q      <= '0;
      i2c_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      slave_q       <= slave_d;
      reg_q         <= reg_d;
      is_read_q     <= is_read_d;
      len_q         <= len_d;
      remaining_q   <= remaining_d;
      tmo_q         <= tmo_d;
      grd_q         <= grd_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      i2c_slave_q   <= i2c_slave_d;
      i2c_reg_q     <= i2c_reg_d;
      i2c_is_read_q <= i2c_is_read_d;
      i2c_nb_q      <= i2c_nb_d;
      i2c_wr_q      <= i2c_wr_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (bus.cmd_valid) state_d = S_CHECK;
      S_CHECK:    state_d = bad_len ? S_IDLE : (is_read_q ? S_START : S_PREFETCH);
      S_PREFETCH: if (bus.wr_valid) state_d = S_START;
      S_START:    state_d = S_XFER;
      S_XFER: begin
        if (byte_evt) begin
          if (need_next && !bus.wr_valid)   state_d = S_ABORT;
          else if (remaining_q == 17'd1)    state_d = S_GUARD;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end
      end
      S_GUARD:    if (grd_q == GRD_W'(1)) state_d = S_FINISH;
      S_FINISH:   state_d = S_IDLE;
      S_ABORT:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output pulses and datapath updates for the current state.
  always_comb begin
    slave_d       = slave_q;
    reg_d         = reg_q;
    is_read_d     = is_read_q;
    len_d         = len_q;
    remaining_d   = remaining_q;
    tmo_d         = tmo_q;
    grd_d         = grd_q;
    err_code_d    = err_code_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    i2c_slave_d   = i2c_slave_q;
    i2c_reg_d     = i2c_reg_q;
    i2c_is_read_d = i2c_is_read_q;
    i2c_nb_d      = i2c_nb_q;
    i2c_wr_d      = i2c_wr_q;
    cmd_ready_c   = (state_q == S_IDLE);
    i2c_start_c   = (state_q == S_START);
    i2c_reset_c   = (state_q == S_ABORT);
    // Write bytes are consumed in the same cycle they are sampled.
    wr_ready_c    = ((state_q == S_PREFETCH) || need_next) && bus.wr_valid;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          slave_d    = bus.cmd_slave_addr;
          reg_d      = bus.cmd_reg_addr;
          is_read_d  = bus.cmd_is_read;
          len_d      = bus.cmd_len;
          err_code_d = 2'd0;
          busy_d     = 1'b1;
        end
      end
      S_CHECK: begin
        if (bad_len) begin
          err_code_d = 2'd1;
          error_d    = 1'b1;
          busy_d     = 1'b0;
        end else begin
          i2c_slave_d   = slave_q;
          i2c_reg_d     = reg_q;
          i2c_is_read_d = is_read_q;
          i2c_nb_d      = len_q - 17'd1;
          remaining_d   = len_q;
        end
      end
      S_PREFETCH: begin
        if (bus.wr_valid) i2c_wr_d = bus.wr_data;
      end
      S_START: tmo_d = TMO_W'(TIMEOUT_CYC);
      S_XFER: begin
        if (byte_evt) begin
          remaining_d = remaining_q - 17'd1;
          i2c_nb_d    = (i2c_nb_q == 17'd0) ? 17'd0 : i2c_nb_q - 17'd1;
          tmo_d       = TMO_W'(TIMEOUT_CYC);
          if (is_read_q) begin
            rd_data_d  = bus.i2c_data_rd;
            rd_valid_d = 1'b1;
          end else if (need_next) begin
            if (bus.wr_valid) i2c_wr_d   = bus.wr_data;
            else              err_code_d = 2'd3;
          end
          if (remaining_q == 17'd1) grd_d = GRD_W'(GUARD_CYC);
        end else if (tmo_hit) begin
          err_code_d = 2'd2;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_GUARD: grd_d = grd_q - GRD_W'(1);
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      S_ABORT: begin
        error_d       = 1'b1;
        busy_d        = 1'b0;
        remaining_d   = '0;
        i2c_slave_d   = '0;
        i2c_reg_d     = '0;
        i2c_is_read_d = 1'b0;
        i2c_nb_d      = '0;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready      = cmd_ready_c;
  assign bus.wr_ready       = wr_ready_c;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.err_code       = err_code_q;
  assign bus.i2c_start      = i2c_start_c;
  assign bus.i2c_slave_addr = i2c_slave_q;
  assign bus.i2c_reg_addr   = i2c_reg_q;
  assign bus.i2c_is_read    = i2c_is_read_q;
  assign bus.i2c_nb_bytes   = i2c_nb_q;
  assign bus.i2c_data_wr    = i2c_wr_q;
  assign bus.i2c_reset      = i2c_reset_c;

endmodule

// File: tb/tb_tof_i2c_txn_sequencer.sv
// Self-checking bench: directed scenarios plus randomized read/write commands
// checked against a byte-list model of the expected engine/stream activity.
module tb_tof_i2c_txn_sequencer;
  localparam int MAX_LEN = 512;
  localparam int TMO     = 300;
  localparam int GUARD   = 8;

  typedef logic [7:0] bq_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int   start_cnt = 0, done_cnt = 0, err_cnt = 0, ireset_cnt = 0, both_cnt = 0;
  bq_t  rd_log;
  bq_t  wr_fifo;
  logic wr_en = 1'b1;

  tof_i2c_txn_sequencer_if bus();

  tof_i2c_txn_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO), .GUARD_CYC(GUARD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Pulse and stream monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.i2c_start) start_cnt++;
    if (bus.done) done_cnt++;
    if (bus.error) err_cnt++;
    if (bus.i2c_reset) ireset_cnt++;
    if (bus.done && bus.error) both_cnt++;
    if (bus.rd_valid) rd_log.push_back(bus.rd_data);
  end

  // Write-byte source: present the queue head, pop when the sequencer takes it.
  always @(negedge clock) begin
    bus.wr_valid = wr_en && (wr_fifo.size() > 0);
    bus.wr_data  = (wr_fifo.size() > 0) ? wr_fifo[0] : 8'h00;
  end
  always @(posedge clock) begin
    if (bus.wr_ready && bus.wr_valid && wr_fifo.size() > 0) void'(wr_fifo.pop_front());
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input bit rd, input logic [6:0] sa, input logic [15:0] ra,
                          input logic [16:0] len);
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clock); n++; end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_is_read = rd; bus.cmd_slave_addr = sa;
    bus.cmd_reg_addr = ra; bus.cmd_len = len;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (!bus.i2c_start && n < 50) begin @(negedge clock); n++; end
    ok = bus.i2c_start;
  endtask

  task automatic wait_error(input int limit, output int cyc);
    cyc = 0;
    while (!bus.error && cyc < limit) begin @(negedge clock); cyc++; end
  endtask

  // Full transaction that is expected to complete; bytes_in empty -> random bytes.
  task automatic run_ok(input bit rd, input logic [6:0] sa, input logic [15:0] ra,
                        input int len, input int maxgap, input bq_t bytes_in);
    bq_t bytes;
    int s0, d0, e0, lat;
    bit ok;
    bytes = bytes_in;
    if (bytes.size() == 0) for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
    if (!rd) wr_fifo = bytes;
    rd_log = {};
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    send_cmd(rd, sa, ra, 17'(len));
    wait_start(ok);
    chk("start_seen", {31'd0, ok}, 32'd1);
    @(negedge clock);
    for (int k = 0; k < len; k++) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clock);
      bus.i2c_ready = 1'b1;
      bus.i2c_data_rd = rd ? bytes[k] : 8'($urandom);
      if (!rd) chk("data_wr", {24'd0, bus.i2c_data_wr}, {24'd0, bytes[k]});
      chk("nb_bytes", {15'd0, bus.i2c_nb_bytes}, 32'(len - 1 - k));
      chk("slave_addr", {25'd0, bus.i2c_slave_addr}, {25'd0, sa});
      chk("reg_addr", {16'd0, bus.i2c_reg_addr}, {16'd0, ra});
      chk("is_read", {31'd0, bus.i2c_is_read}, {31'd0, rd});
      @(negedge clock);
      bus.i2c_ready = 1'b0;
    end
    lat = 1;
    while (!bus.done && lat < GUARD + 20) begin @(negedge clock); lat++; end
    chk("done_latency", 32'(lat), 32'(GUARD + 2));
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    chk("err_code_ok", {30'd0, bus.err_code}, 32'd0);
    @(negedge clock);
    chk("start_once", 32'(start_cnt - s0), 32'd1);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("no_error", 32'(err_cnt - e0), 32'd0);
    if (rd) begin
      chk("rd_count", 32'(rd_log.size()), 32'(len));
      for (int k = 0; k < len && k < rd_log.size(); k++)
        chk("rd_byte", {24'd0, rd_log[k]}, {24'd0, bytes[k]});
    end else begin
      chk("wr_all_taken", 32'(wr_fifo.size()), 32'd0);
    end
  endtask

  task automatic bad_len(input logic [16:0] len);
    int s0, r0, cyc;
    s0 = start_cnt; r0 = ireset_cnt;
    send_cmd(1'b0, 7'h29, 16'h0001, len);
    wait_error(10, cyc);
    chk("badlen_error", {31'd0, bus.error}, 32'd1);
    chk("badlen_code", {30'd0, bus.err_code}, 32'd1);
    chk("badlen_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clock);
    chk("badlen_no_start", 32'(start_cnt - s0), 32'd0);
    chk("badlen_no_ireset", 32'(ireset_cnt - r0), 32'd0);
  endtask

  initial begin
    bq_t fixed;
    int cyc, r0, d0, e0, s0;
    bit ok;
    bus.cmd_valid = 0; bus.cmd_is_read = 0; bus.cmd_slave_addr = 0; bus.cmd_reg_addr = 0;
    bus.cmd_len = 0; bus.i2c_data_rd = 0; bus.i2c_ready = 0;
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);
    chk("rst_nb", {15'd0, bus.i2c_nb_bytes}, 32'd0);
    chk("rst_pulses", {27'd0, bus.done, bus.error, bus.i2c_start, bus.i2c_reset, bus.rd_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed write of two bytes.
    fixed = {8'hAA, 8'h55};
    run_ok(1'b0, 7'h29, 16'h7FFF, 2, 2, fixed);
    // Directed read of three bytes.
    fixed = {8'h11, 8'h22, 8'h33};
    run_ok(1'b1, 7'h29, 16'h0010, 3, 2, fixed);

    // Length boundaries.
    bad_len(17'd0);
    bad_len(17'(MAX_LEN + 1));
    fixed = {};
    run_ok(1'b1, 7'h52, 16'h1234, MAX_LEN, 0, fixed);

    // Write underrun at the first engine byte pulse.
    wr_fifo = {8'hAA};
    r0 = ireset_cnt; d0 = done_cnt;
    send_cmd(1'b0, 7'h29, 16'h0020, 17'd2);
    wait_start(ok);
    chk("ur_start", {31'd0, ok}, 32'd1);
    @(negedge clock);
    wr_en = 1'b1;
    bus.i2c_ready = 1'b1;
    @(negedge clock);
    bus.i2c_ready = 1'b0;
    wait_error(10, cyc);
    chk("ur_error", {31'd0, bus.error}, 32'd1);
    chk("ur_code", {30'd0, bus.err_code}, 32'd3);
    chk("ur_addr_zero", {25'd0, bus.i2c_slave_addr}, 32'd0);
    @(negedge clock);
    chk("ur_ireset", 32'(ireset_cnt - r0), 32'd1);
    chk("ur_no_done", 32'(done_cnt - d0), 32'd0);

    // Engine never answers: timeout.
    r0 = ireset_cnt;
    send_cmd(1'b1, 7'h29, 16'h0030, 17'd1);
    wait_start(ok);
    chk("to_start", {31'd0, ok}, 32'd1);
    wait_error(TMO + 20, cyc);
    chk("to_error", {31'd0, bus.error}, 32'd1);
    chk("to_window", 32'(cyc >= TMO && cyc <= TMO + 3), 32'd1);
    chk("to_code", {30'd0, bus.err_code}, 32'd2);
    @(negedge clock);
    chk("to_ireset", 32'(ireset_cnt - r0), 32'd1);

    // Reset in the middle of a 4-byte read.
    send_cmd(1'b1, 7'h33, 16'hBEEF, 17'd4);
    wait_start(ok);
    @(negedge clock);
    repeat (2) begin
      bus.i2c_ready = 1'b1; @(negedge clock); bus.i2c_ready = 1'b0; @(negedge clock);
    end
    d0 = done_cnt; e0 = err_cnt;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_addr", {9'd0, bus.i2c_slave_addr, bus.i2c_reg_addr}, 32'd0);
    chk("mid_rst_nb", {15'd0, bus.i2c_nb_bytes}, 32'd0);
    reset = 1'b0;
    repeat (GUARD + 4) @(negedge clock);
    chk("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    fixed = {};
    run_ok(1'b1, 7'h33, 16'hBEEF, 4, 1, fixed);

    // Randomized commands.
    for (int t = 0; t < 10; t++) begin
      fixed = {};
      run_ok(1'($urandom), 7'($urandom), 16'($urandom), $urandom_range(6, 1), 3, fixed);
    end

    s0 = start_cnt;
    repeat (5) @(negedge clock);
    chk("idle_no_start", 32'(start_cnt - s0), 32'd0);
    chk("done_error_exclusive", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
